// File: rtl/in_n_clock.sv
// in_n_clock -- measures the length of high runs on a pulse line.
//
// Counts consecutive posedges at which `in` is sampled high. When the run
// ends (first low sample), the count is presented on `len` with a one-clock
// `dav` strobe. Runs longer than 2^W-1 clocks saturate and flag `ovf`.
//
// Optional feature: define IN_N_CLOCK_CHECK_EN to build the run-length
// check. When enabled, `err` flags runs that saturated or whose length
// differs from N. When undefined, `err` is tied to 0 and N is unused.
//
// Ports:
//   clock   in   single clock, all state updates on posedge
//   reset_  in   asynchronous active-low reset
//   in      in   pulse line under measurement
//   len     out  [W-1:0] length of the last completed run
//   dav     out  one-clock strobe per completed run
//   ovf     out  last completed run exceeded 2^W-1 clocks
//   err     out  last completed run length differed from N (check only)
//
// state | meaning
// IDLE  | line low, waiting for a run to start
// HIGH  | run in progress, count below saturation
// SAT   | run in progress, count pinned at 2^W-1
module in_n_clock #(
  parameter int N = 3,
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         in,
  output logic [W-1:0] len,
  output logic         dav,
  output logic         ovf,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    SAT  = 2'd2
  } state_t;

  localparam logic [W-1:0] CNT_MAX = '1;

  state_t       state, state_nxt;
  logic [W-1:0] count, count_nxt;
  logic [W-1:0] len_nxt;
  logic         dav_nxt;
  logic         ovf_nxt;
  logic         run_done;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    len_nxt   = len;
    dav_nxt   = 1'b0;
    ovf_nxt   = ovf;
    run_done  = 1'b0;
    case (state)
      IDLE: begin
        if (in) begin
          count_nxt = W'(1);
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (in) begin
          if (count != CNT_MAX) begin
            count_nxt = count + 1'b1;
          end else begin
            state_nxt = SAT;
          end
        end else begin
          run_done  = 1'b1;
          len_nxt   = count;
          dav_nxt   = 1'b1;
          ovf_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      SAT: begin
        if (!in) begin
          run_done  = 1'b1;
          len_nxt   = count;
          dav_nxt   = 1'b1;
          ovf_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
      count <= '0;
      len   <= '0;
      dav   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      len   <= len_nxt;
      dav   <= dav_nxt;
      ovf   <= ovf_nxt;
    end
  end

`ifdef IN_N_CLOCK_CHECK_EN
  logic err_nxt;

  // A saturated run is always an error, even if N happens to be 2^W-1.
  always_comb begin
    err_nxt = err;
    if (run_done) begin
      err_nxt = (state == SAT) || (int'(count) != N);
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      err <= 1'b0;
    end else begin
      err <= err_nxt;
    end
  end
`else
  logic unused_check;

  assign err          = 1'b0;
  assign unused_check = run_done ^ (N == 0);
`endif

endmodule

// File: doc/in_n_clock.md
IN_N_CLOCK -- requirements
Module: in_n_clock

Interface
REQ-001 SHALL have parameter N, default 3: the expected high-run length in clocks; used only by the check feature.
REQ-002 SHALL have parameter W, default 4: width of the run counter and of len.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its posedge.
REQ-004 SHALL have port reset_, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in, input, 1 bit: the pulse line under measurement, sampled at posedge clock.
REQ-006 SHALL have port len, output, W bits: length of the last completed high run.
REQ-007 SHALL have port dav, output, 1 bit: data-valid strobe, high for one clock per completed run.
REQ-008 SHALL have port ovf, output, 1 bit: the last completed run exceeded 2^W-1 clocks.
REQ-009 SHALL have port err, output, 1 bit: the last completed run length differs from N (check feature only).

Function
REQ-010 SHALL define run length as the number of consecutive posedges at which in is sampled 1.
REQ-011 SHALL implement states IDLE, HIGH and SAT; all outputs SHALL be registered.
REQ-012 In IDLE with in=1, SHALL set COUNT to 1 and go to HIGH; with in=0, SHALL stay in IDLE.
REQ-013 In HIGH with in=1 and COUNT<2^W-1, SHALL increment COUNT and stay in HIGH.
REQ-014 In HIGH with in=1 and COUNT=2^W-1, SHALL hold COUNT and go to SAT.
REQ-015 In SAT with in=1, SHALL stay in SAT with COUNT held at 2^W-1.
REQ-016 On the edge sampling in=0 in HIGH or SAT, SHALL load len with COUNT and assert dav, then go to IDLE.
REQ-017 On that same edge, ovf SHALL be loaded with 1 if leaving SAT and 0 if leaving HIGH.
REQ-018 dav SHALL be high for exactly one clock period; len and ovf SHALL hold until the next dav.
REQ-019 Latency: dav, len and ovf SHALL be valid immediately after the edge that samples the first 0 following a run.
REQ-020 Back-to-back runs separated by one low sample SHALL each be measured, with no run lost.
REQ-021 A run still in progress when reset is asserted SHALL be discarded, with no dav produced.
REQ-022 A line held at 1 when reset is released SHALL be measured from the first sampled edge.

Reset
REQ-023 While reset_=0, SHALL force state IDLE, COUNT=0, len=0, dav=0, ovf=0 and err=0, independent of clock.
REQ-024 The first state update after reset_ rises SHALL occur on the next posedge clock.

Configuration
REQ-025 With macro IN_N_CLOCK_CHECK_EN defined, err SHALL be loaded on each dav edge with 1 if (the run saturated or COUNT≠N) and 0 otherwise, and held until the next dav.
REQ-026 Without IN_N_CLOCK_CHECK_EN, err SHALL be constant 0 and no comparison logic SHALL be built; the N parameter SHALL be ignored.

Verification
REQ-027 Reset, then in=1 for 3 edges, then 0 -> one dav pulse, len=3, ovf=0, err=0 (with CHECK_EN).
REQ-028 Pattern 1,1,1,0 repeated 4 times (the output of a matching N=3 generator) -> 4 dav pulses, each with len=3 and err=0.
REQ-029 in=1 for 20 edges, then 0 -> single dav, len=15, ovf=1, err=1 (with CHECK_EN); the next run of 2 gives len=2, ovf=0, err=1.
REQ-030 in=1 for 2 edges, reset_ pulsed low mid-run, in=0 -> no dav; all outputs stay 0.
REQ-031 Single-cycle pulses 1,0,1,0 -> 2 dav pulses, len=1 each, err=1 (with CHECK_EN), err=0 (without).
REQ-032 in held 0 for 50 edges -> dav never asserted; len=0 throughout.
